// File: rtl/uart_msg_pkg.sv
// Shared types and message ROM for the UART message transmitter.
// UART_MSG_PARITY_EN adds the TX_PARITY state to tx_state_t.
package uart_msg_pkg;

   localparam int MSG_LEN = 7;

   // "Hello\r\n", MSG[0] is the first character on the wire
   localparam logic [0:MSG_LEN-1][7:0] MSG = {8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_MSG_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_WAIT_HI,
      SEQ_WAIT_LO,
      SEQ_GAP
   } seq_state_t;

endpackage

// File: rtl/uart_msg_tx_core.sv
// Baud divider and 8N1 transmitter FSM (8E1 when UART_MSG_PARITY_EN is defined).
// busy covers start bit through stop bit; byte_done marks the last stop-bit clock.
module uart_msg_tx_core
   import uart_msg_pkg::*;
#(
   parameter int CLK_HZ = 25000000,
   parameter int BAUD   = 115200
) (
   input  logic       clk_25mhz,
   input  logic       resetn,
   input  logic [7:0] data,
   input  logic       start_tx,
   output logic       busy,
   output logic       tx,
   output logic       byte_done
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

   tx_state_t      state, state_nxt;
   logic [BW-1:0]  baud_cnt;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign busy    = (state != TX_IDLE);

   always_ff @(posedge clk_25mhz or negedge resetn) begin
      if (!resetn) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         state <= state_nxt;
         if (state == TX_IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (start_tx) shreg <= data;
         end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
            if (bit_end && state == TX_DATA) begin
               shreg   <= {1'b0, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

`ifdef UART_MSG_PARITY_EN
   // Parity is taken at latch time since the shift register is consumed by TX_DATA
   logic par_q;

   always_ff @(posedge clk_25mhz or negedge resetn) begin
      if (!resetn)                          par_q <= 1'b0;
      else if (state == TX_IDLE && start_tx) par_q <= ^data;
   end
`endif

   always_comb begin
      state_nxt = state;
      tx        = 1'b1;
      byte_done = 1'b0;
      case (state)
         TX_IDLE:  if (start_tx) state_nxt = TX_START;
         TX_START: begin
            tx = 1'b0;
            if (bit_end) state_nxt = TX_DATA;
         end
         TX_DATA: begin
            tx = shreg[0];
`ifdef UART_MSG_PARITY_EN
            if (bit_end && bit_cnt == 3'd7) state_nxt = TX_PARITY;
`else
            if (bit_end && bit_cnt == 3'd7) state_nxt = TX_STOP;
`endif
         end
`ifdef UART_MSG_PARITY_EN
         TX_PARITY: begin
            tx = par_q;
            if (bit_end) state_nxt = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (bit_end) begin
               byte_done = 1'b1;
               state_nxt = TX_IDLE;
            end
         end
         default:  state_nxt = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_msg_tx.sv
// Message sequencer: streams the MSG ROM into the UART core while enable is high.
// Optional even parity via UART_MSG_PARITY_EN (handled inside the core).
module uart_msg_tx
   import uart_msg_pkg::*;
#(
   parameter int CLK_HZ     = 25000000,
   parameter int BAUD       = 115200,
   parameter int GAP_CYCLES = 0
) (
   input  logic       clk_25mhz,
   input  logic       resetn,
   input  logic       enable,
   output logic       tx,
   output logic       busy,
   output logic [7:0] data,
   output logic       byte_done
);

   localparam int IW = $clog2(MSG_LEN);
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(MSG_LEN - 1);

   seq_state_t     seq, seq_nxt;
   logic [IW-1:0]  idx, idx_nxt;
   logic [GW-1:0]  gap_cnt;
   logic [7:0]     data_q;
   logic           start_tx;

   assign data = data_q;

   always_ff @(posedge clk_25mhz or negedge resetn) begin
      if (!resetn) begin
         seq     <= SEQ_IDLE;
         idx     <= '0;
         gap_cnt <= '0;
         data_q  <= MSG[0];
      end else begin
         seq     <= seq_nxt;
         idx     <= idx_nxt;
         gap_cnt <= (seq == SEQ_GAP) ? gap_cnt + GW'(1) : '0;
         // data only moves on entry to LOAD, so it holds steady across the frame and idle
         if (seq_nxt == SEQ_LOAD) data_q <= MSG[idx_nxt];
      end
   end

   always_comb begin
      seq_nxt  = seq;
      idx_nxt  = idx;
      start_tx = 1'b0;
      case (seq)
         SEQ_IDLE:    if (enable) seq_nxt = SEQ_LOAD;
         SEQ_LOAD: begin
            start_tx = 1'b1;
            seq_nxt  = SEQ_WAIT_HI;
         end
         SEQ_WAIT_HI: if (busy) seq_nxt = SEQ_WAIT_LO;
         SEQ_WAIT_LO: begin
            if (!busy) begin
               idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
               if (GAP_CYCLES != 0) seq_nxt = SEQ_GAP;
               else                 seq_nxt = enable ? SEQ_LOAD : SEQ_IDLE;
            end
         end
         SEQ_GAP:     if (gap_cnt == GAP_LAST) seq_nxt = enable ? SEQ_LOAD : SEQ_IDLE;
         default:     seq_nxt = SEQ_IDLE;
      endcase
   end

   uart_msg_tx_core #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_core (
      .clk_25mhz (clk_25mhz),
      .resetn    (resetn),
      .data      (data_q),
      .start_tx  (start_tx),
      .busy      (busy),
      .tx        (tx),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: frame-timeline model checked every cycle, a mid-bit
// serial decoder, and directed scenarios with hand-computed expectations.
module tb_uart_msg_tx;

   localparam int DIV = 25000000 / 115200;
`ifdef UART_MSG_PARITY_EN
   localparam int NB = 11;
   localparam int FRAME_LIT = 2387;
`else
   localparam int NB = 10;
   localparam int FRAME_LIT = 2170;
`endif
   localparam int FRAME = NB * DIV;
   localparam int GAP = 0;

   logic       clk_25mhz, resetn, enable;
   logic       tx, busy, byte_done;
   logic [7:0] data;

   uart_msg_tx dut (
      .clk_25mhz (clk_25mhz),
      .resetn    (resetn),
      .enable    (enable),
      .tx        (tx),
      .busy      (busy),
      .data      (data),
      .byte_done (byte_done)
   );

   initial begin
      clk_25mhz = 1'b0;
      forever #20 clk_25mhz = ~clk_25mhz;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   logic [7:0] msg_b [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

   // Wire level of bit slot k of a frame carrying byte b
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_MSG_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Timeline model: a frame starts one clock after the edge that loads it;
   // a load is allowed at an enabled edge once the previous frame has ended
   // and the busy-low handshake clock (plus gap) has passed.
   int         cyc = 0;
   int         m_fs, m_pend, m_idx, m_ready;
   logic [7:0] m_data;

   initial forever begin
      @(posedge clk_25mhz or negedge resetn);
      if (resetn !== 1'b1) begin
         m_fs = -1; m_pend = -1; m_idx = 0; m_ready = 0; m_data = msg_b[0];
      end else begin
         cyc++;
         if (m_fs >= 0 && cyc == m_fs + FRAME) begin
            m_fs    = -1;
            m_idx   = (m_idx + 1) % 7;
            m_ready = cyc + 1 + GAP;
         end
         if (m_pend == cyc) begin
            m_fs   = cyc;
            m_pend = -1;
         end
         if (m_fs < 0 && m_pend < 0 && cyc >= m_ready && enable === 1'b1) begin
            m_data = msg_b[m_idx];
            m_pend = cyc + 1;
         end
      end
   end

   logic e_tx, e_busy, e_done;

   initial forever begin
      @(negedge clk_25mhz);
      if (resetn === 1'b1) begin
         e_busy = (m_fs >= 0);
         e_tx   = e_busy ? frame_bit(m_data, (cyc - m_fs) / DIV) : 1'b1;
         e_done = e_busy && (cyc - m_fs == FRAME - 1);
         n_chk++;
         if ({tx, busy, byte_done, data} !== {e_tx, e_busy, e_done, m_data}) begin
            n_err++;
            $display("FAIL model cyc %0d: tx/busy/done/data got %b/%b/%b/%h expected %b/%b/%b/%h",
                     cyc, tx, busy, byte_done, data, e_tx, e_busy, e_done, m_data);
         end
      end
   end

   // Serial decoder sampling mid-bit, independent of the model
   logic [7:0] dq[$];
   bit         pq[$];
   int         ferr = 0;
   int         dec_s, dec_t;
   logic       tx_prev;
   logic [10:0] dbits;

   initial forever begin
      @(negedge clk_25mhz or negedge resetn);
      if (resetn !== 1'b1) begin
         dec_s = -1; tx_prev = 1'b1;
      end else begin
         if (dec_s < 0) begin
            if (tx_prev === 1'b1 && tx === 1'b0) begin
               dec_s = cyc; dbits = '0;
            end
         end
         if (dec_s >= 0) begin
            dec_t = cyc - dec_s;
            if (dec_t >= DIV/2 && (dec_t - DIV/2) % DIV == 0) begin
               dbits[(dec_t - DIV/2) / DIV] = tx;
               if ((dec_t - DIV/2) / DIV == NB - 1) begin
                  dq.push_back(dbits[8:1]);
                  pq.push_back(dbits[9]);
                  if (dbits[0] !== 1'b0 || dbits[NB-1] !== 1'b1) ferr++;
                  dec_s = -1;
               end
            end
         end
         tx_prev = tx;
      end
   end

   int n_done = 0;
   int blen = 0, last_blen = 0;

   initial forever begin
      @(negedge clk_25mhz or negedge resetn);
      if (resetn !== 1'b1) blen = 0;
      else begin
         if (byte_done === 1'b1) n_done++;
         if (busy === 1'b1) blen++;
         else if (blen != 0) begin last_blen = blen; blen = 0; end
      end
   end

   task automatic wait_busy(input logic v, input int budget);
      int n = 0;
      while (busy !== v && n < budget) begin @(negedge clk_25mhz); n++; end
      chk("wait_busy_timeout", busy, v);
   endtask

   task automatic wait_dec(input int cnt, input int budget);
      int n = 0;
      while (dq.size() < cnt && n < budget) begin @(negedge clk_25mhz); n++; end
      chk("wait_decode_timeout", dq.size() >= cnt, 1);
   endtask

   int lat, run, d0, bad, n0;
   logic [7:0] exp8 [8] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A, 8'h48};

   initial begin
      resetn = 1'b0; enable = 1'b0;
      repeat (3) @(negedge clk_25mhz);
      resetn = 1'b1;
      repeat (5) @(negedge clk_25mhz);

      // Short reset pulse while idle
      #5 resetn = 1'b0;
      #5 resetn = 1'b1;
      #1;
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_data", data, 8'h48);
      chk("reset_byte_done", byte_done, 1'b0);
      @(negedge clk_25mhz);

      // First frame after enable
      d0 = n_done;
      enable = 1'b1;
      lat = 0;
      do begin @(negedge clk_25mhz); lat++; end while (tx !== 1'b0 && lat < 10);
      chk("enable_to_tx_low", lat, 2);
      run = 0;
      while (tx === 1'b0 && run < 5000) begin run++; @(negedge clk_25mhz); end
      chk("first_low_run_start_plus_3_zeros", run, 868);
      wait_busy(1'b0, 3000);
      @(negedge clk_25mhz);
      chk("busy_frame_len", last_blen, FRAME_LIT);
      chk("byte_done_pulses", n_done - d0, 1);
      chk("first_byte_count", dq.size(), 1);
      chk("first_byte", dq[0], 8'h48);

      // Continuous run through the wrap
      wait_dec(8, 8 * 2400);
      for (int i = 0; i < 8; i++) chk($sformatf("stream_byte%0d", i), dq[i], exp8[i]);
`ifdef UART_MSG_PARITY_EN
      chk("parity_0x48", pq[0], 1'b0);
      chk("parity_0x6C", pq[2], 1'b0);
      chk("parity_0x0D", pq[5], 1'b1);
`endif

      // Drop enable during the data bits of 0x65
      wait_busy(1'b0, 3000);
      wait_busy(1'b1, 10);
      repeat (700) @(negedge clk_25mhz);
      enable = 1'b0;
      wait_busy(1'b0, 3000);
      @(negedge clk_25mhz);
      chk("drop_count", dq.size(), 9);
      chk("drop_byte_intact", dq[8], 8'h65);
      bad = 0;
      repeat (3000) begin
         @(negedge clk_25mhz);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("idle_after_drop", bad, 0);
      enable = 1'b1;
      wait_decode_and_check: begin
         wait_dec(10, 3000);
         chk("reenable_byte", dq[9], 8'h6C);
      end

      // Reset in the middle of the data bits
      wait_busy(1'b0, 3000);
      wait_busy(1'b1, 10);
      repeat (600) @(negedge clk_25mhz);
      #3 resetn = 1'b0;
      #1;
      chk("midframe_reset_tx", tx, 1'b1);
      chk("midframe_reset_busy", busy, 1'b0);
      #5 resetn = 1'b1;
      n0 = dq.size();
      wait_dec(n0 + 1, 3000);
      chk("after_reset_byte", dq[n0], 8'h48);

      enable = 1'b0;
      wait_busy(1'b0, 3000);
      repeat (5) @(negedge clk_25mhz);
      chk("framing_errors", ferr, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
